// File: rtl/key_player.sv
// Replays queued note events onto the one-hot keys bus: each note is pressed for
// its programmed number of ticks, then followed by a fixed all-keys-released gap.
module key_player #(
   parameter int unsigned num_keys   = 24,
   parameter int unsigned dur_w      = 8,
   parameter int unsigned tick_div   = 50000,
   parameter int unsigned gap_ticks  = 10,
   parameter int unsigned fifo_depth = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic [4:0]          note_key,
   input  logic [dur_w-1:0]    note_dur,
   input  logic                note_valid,
   output logic                note_ready,
   output logic [num_keys-1:0] keys,
   output logic [4:0]          key,
   output logic                busy,
   output logic                done
);

   localparam int unsigned PtrW = $clog2(fifo_depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned PscW = (tick_div > 1) ? $clog2(tick_div) : 1;
   localparam int unsigned GapW = $clog2(gap_ticks + 1);
   localparam int unsigned TckW = (dur_w > GapW) ? dur_w : GapW;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StPress = 2'd1;
   localparam logic [1:0] StGap   = 2'd2;

   localparam logic [num_keys-1:0] KeyLsb = {{(num_keys-1){1'b0}}, 1'b1};

   logic [1:0]          r_state;
   logic [CntW-1:0]     r_count;
   logic [PtrW-1:0]     r_wr_ptr;
   logic [PtrW-1:0]     r_rd_ptr;
   logic [4:0]          r_fifo_key [fifo_depth];
   logic [dur_w-1:0]    r_fifo_dur [fifo_depth];
   logic [PscW-1:0]     r_presc;
   logic [TckW-1:0]     r_tcnt;
   logic                r_rdy_en;
   logic [num_keys-1:0] r_keys;
   logic [4:0]          r_key;
   logic                r_done;

   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic                w_tick;
   logic                w_last;
   logic [4:0]          w_head_key;
   logic [dur_w-1:0]    w_head_dur;
   logic [num_keys-1:0] w_onehot;

   // r_rdy_en holds note_ready low until the first edge after reset release
   assign w_full     = (r_count == CntW'(fifo_depth));
   assign note_ready = r_rdy_en & ~w_full & ~clear;
   assign w_push     = note_valid & note_ready;
   assign w_pop      = (r_state == StIdle) & (r_count != '0) & ~clear;
   assign w_head_key = r_fifo_key[r_rd_ptr];
   assign w_head_dur = r_fifo_dur[r_rd_ptr];
   assign w_tick     = (r_presc == PscW'(tick_div - 1));
   assign w_last     = w_tick & (r_tcnt == TckW'(1));
   assign w_onehot   = (32'(w_head_key) < num_keys) ? (KeyLsb << w_head_key) : '0;

   assign keys = r_keys;
   assign key  = r_key;
   assign done = r_done;
   assign busy = (r_state != StIdle) | (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_key[r_wr_ptr] <= note_key;
         r_fifo_dur[r_wr_ptr] <= note_dur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clear) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
         r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_presc  <= '0;
         r_tcnt   <= '0;
         r_rdy_en <= 1'b0;
         r_keys   <= '0;
         r_key    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         r_done   <= 1'b0;
         // Prescaler idles at 0, so every entry into PRESS or GAP starts a full tick
         r_presc  <= (clear || r_state == StIdle || w_tick) ? '0 : r_presc + PscW'(1);
         if (clear) begin
            r_state <= StIdle;
            r_keys  <= '0;
         end else begin
            case (r_state)
               StIdle: begin
                  if (w_pop && w_head_dur != '0) begin
                     r_state <= StPress;
                     r_tcnt  <= TckW'(w_head_dur);
                     r_key   <= w_head_key;
                     r_keys  <= w_onehot;
                  end
               end
               StPress: begin
                  if (w_last) begin
                     r_state <= StGap;
                     r_tcnt  <= TckW'(gap_ticks);
                     r_keys  <= '0;
                  end else if (w_tick) begin
                     r_tcnt <= r_tcnt - TckW'(1);
                  end
               end
               StGap: begin
                  if (w_last) begin
                     r_state <= StIdle;
                     r_done  <= 1'b1;
                  end else if (w_tick) begin
                     r_tcnt <= r_tcnt - TckW'(1);
                  end
               end
               default: begin
                  r_state <= StIdle;
                  r_keys  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_player.sv
// Randomized and directed bench for key_player against a queue-based timeline model.
module tb_key_player;

   localparam int unsigned NumKeys  = 24;
   localparam int unsigned DurW     = 8;
   localparam int unsigned TickDiv  = 4;
   localparam int unsigned GapTicks = 2;
   localparam int unsigned Depth    = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                clear = 1'b0;
   logic [4:0]          note_key = '0;
   logic [DurW-1:0]     note_dur = '0;
   logic                note_valid = 1'b0;
   logic                note_ready;
   logic [NumKeys-1:0]  keys;
   logic [4:0]          key;
   logic                busy;
   logic                done;

   key_player #(
      .num_keys   (NumKeys),
      .dur_w      (DurW),
      .tick_div   (TickDiv),
      .gap_ticks  (GapTicks),
      .fifo_depth (Depth)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .note_key   (note_key),
      .note_dur   (note_dur),
      .note_valid (note_valid),
      .note_ready (note_ready),
      .keys       (keys),
      .key        (key),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] k;
      logic [7:0] d;
   } note_t;

   int checks = 0;
   int errors = 0;

   // Model: a note queue plus the number of cycles left in the current press or gap
   note_t        q[$];
   int           m_phase = 0;   // 0 waiting, 1 sounding, 2 gap
   int           m_left  = 0;
   logic [23:0]  m_keys  = '0;
   logic [4:0]   m_key   = '0;
   logic         m_done  = 1'b0;
   logic         m_rdy_en = 1'b0;
   logic         m_acc   = 1'b0;

   int   dut_dones = 0;
   int   hi_cycles = 0;
   int   k7_rises  = 0;
   logic prev_k7   = 1'b0;
   logic dut_rdy   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic m_ready(input logic clr);
      return m_rdy_en && (q.size() < Depth) && !clr;
   endfunction

   task automatic model_edge(input logic v, input logic [4:0] k, input logic [7:0] d,
                             input logic clr);
      note_t e;
      note_t n;
      m_acc  = v && m_ready(clr);
      m_done = 1'b0;
      if (clr) begin
         q.delete();
         m_phase = 0;
         m_keys  = '0;
      end else begin
         if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) begin
               m_phase = 2;
               m_left  = GapTicks * TickDiv;
               m_keys  = '0;
            end
         end else if (m_phase == 2) begin
            m_left--;
            if (m_left == 0) begin
               m_phase = 0;
               m_done  = 1'b1;
            end
         end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.d != 0) begin
               m_phase = 1;
               m_left  = int'(e.d) * TickDiv;
               m_key   = e.k;
               m_keys  = (e.k < NumKeys) ? (24'(1) << e.k) : '0;
            end
         end
         if (m_acc) begin
            n.k = k;
            n.d = d;
            q.push_back(n);
         end
      end
      m_rdy_en = 1'b1;
   endtask

   task automatic cycle(input logic v, input logic [4:0] k, input logic [7:0] d, input logic clr);
      note_valid = v;
      note_key   = k;
      note_dur   = d;
      clear      = clr;
      #1;
      dut_rdy = note_ready;
      check_eq("note_ready", 32'(note_ready), 32'(m_ready(clr)));
      @(posedge clk);
      model_edge(v, k, d, clr);
      #1;
      check_eq("keys", 32'(keys), 32'(m_keys));
      check_eq("key", 32'(key), 32'(m_key));
      check_eq("done", 32'(done), 32'(m_done));
      check_eq("busy", 32'(busy), 32'((m_phase != 0) || (q.size() != 0)));
      if (done) dut_dones++;
      if (keys != '0) hi_cycles++;
      if (keys[7] && !prev_k7) k7_rises++;
      prev_k7 = keys[7];
   endtask

   task automatic push_note(input logic [4:0] k, input logic [7:0] d, output int stalls);
      int n = 0;
      stalls = 0;
      do begin
         cycle(1'b1, k, d, 1'b0);
         if (!dut_rdy) stalls++;
         n++;
      end while (!m_acc && n < 500);
      if (!m_acc) check_eq("push_timeout", 32'(n), 32'(0));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 8'd0, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while ((m_phase != 0 || q.size() != 0) && n < 3000) begin
         cycle(1'b0, 5'd0, 8'd0, 1'b0);
         n++;
      end
      if (n >= 3000) check_eq("drain_timeout", 32'(n), 32'(0));
      idle(2);
   endtask

   task automatic clear_counts();
      dut_dones = 0;
      hi_cycles = 0;
      k7_rises  = 0;
   endtask

   task automatic async_reset_mid();
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      m_phase  = 0;
      m_left   = 0;
      m_keys   = '0;
      m_key    = '0;
      m_done   = 1'b0;
      m_rdy_en = 1'b0;
      check_eq("arst_keys", 32'(keys), 32'(0));
      check_eq("arst_key", 32'(key), 32'(0));
      check_eq("arst_ready", 32'(note_ready), 32'(0));
      check_eq("arst_busy", 32'(busy), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int st;
      int free_pushes;
      logic stalled;

      #1;
      check_eq("reset_keys", 32'(keys), 32'(0));
      check_eq("reset_key", 32'(key), 32'(0));
      check_eq("reset_done", 32'(done), 32'(0));
      check_eq("reset_busy", 32'(busy), 32'(0));
      check_eq("reset_ready", 32'(note_ready), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check_eq("ready_after_reset", 32'(note_ready), 32'(1));

      // Single note
      clear_counts();
      push_note(5'd5, 8'd3, st);
      drain();
      check_eq("single_dones", 32'(dut_dones), 32'(1));
      check_eq("single_hi", 32'(hi_cycles), 32'(12));

      // Repeated key gives two separate presses
      clear_counts();
      push_note(5'd7, 8'd1, st);
      push_note(5'd7, 8'd1, st);
      drain();
      check_eq("repeat_rises", 32'(k7_rises), 32'(2));
      check_eq("repeat_dones", 32'(dut_dones), 32'(2));
      check_eq("repeat_hi", 32'(hi_cycles), 32'(8));

      // Backpressure with valid held high
      clear_counts();
      free_pushes = 0;
      stalled = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push_note(5'(i), 8'd5, st);
         if (st != 0) stalled = 1'b1;
         if (!stalled) free_pushes++;
      end
      drain();
      check_eq("bp_free_accepts", 32'(free_pushes), 32'(5));
      check_eq("bp_dones", 32'(dut_dones), 32'(6));
      check_eq("bp_hi", 32'(hi_cycles), 32'(6 * 5 * TickDiv));

      // Rest, dropped note, top key
      clear_counts();
      push_note(5'd30, 8'd2, st);
      push_note(5'd3, 8'd0, st);
      push_note(5'd23, 8'd1, st);
      drain();
      check_eq("rest_dones", 32'(dut_dones), 32'(2));
      check_eq("rest_hi", 32'(hi_cycles), 32'(4));
      check_eq("rest_key", 32'(key), 32'(23));

      // Clear during a press with notes queued
      push_note(5'd10, 8'd3, st);
      push_note(5'd1, 8'd1, st);
      push_note(5'd2, 8'd1, st);
      idle(2);
      check_eq("clr_pre_keys", 32'(keys), 32'h400);
      cycle(1'b1, 5'd4, 8'd1, 1'b1);
      check_eq("clr_keys", 32'(keys), 32'(0));
      check_eq("clr_busy", 32'(busy), 32'(0));
      clear_counts();
      idle(100);
      check_eq("clr_dones", 32'(dut_dones), 32'(0));
      check_eq("clr_hi", 32'(hi_cycles), 32'(0));

      // Asynchronous reset during a press
      push_note(5'd12, 8'd4, st);
      push_note(5'd13, 8'd2, st);
      idle(3);
      check_eq("arst_pre_keys", 32'(keys), 32'h1000);
      async_reset_mid();
      idle(2);
      check_eq("arst_ready_after", 32'(note_ready), 32'(1));
      check_eq("arst_busy_after", 32'(busy), 32'(0));

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 3)),
               1'($urandom_range(0, 63) == 0));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
